// File: rtl/hps_cop_cmd_sequencer_pkg.sv
//------------------------------------------------------------------------------
// Module  : cop_ctrl_pkg
// Brief   : Shared state and status encodings for the HPS coprocessor sequencer.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package cop_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    // Codes the HPS reads back on the WAITSIGNAL PIO.
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_BUSY = 2'b01;
    localparam logic [1:0] ST_OK   = 2'b10;
    localparam logic [1:0] ST_ERR  = 2'b11;

    function automatic logic [1:0] status_for(input logic err);
        return err ? ST_ERR : ST_OK;
    endfunction

endpackage

`default_nettype wire

// File: rtl/hps_cop_cmd_sequencer_timer.sv
//------------------------------------------------------------------------------
// Module  : cop_timeout_timer
// Brief   : Saturating issue-to-done timer; expires on its last allowed cycle.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module cop_timeout_timer #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam int TMR_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int LAST_INT = (TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0;
    localparam logic [TMR_W-1:0] LAST_CNT = TMR_W'(LAST_INT);

    logic [TMR_W-1:0] count_q;
    logic [TMR_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (i_clear) begin
            count_d = '0;
        end else if (i_enable && (count_q != {TMR_W{1'b1}})) begin
            count_d = count_q + TMR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // A zero budget folds this to a constant low, so the timer never fires.
    assign o_expire = (TIMEOUT_CYCLES != 0) && i_enable && (count_q == LAST_CNT);

endmodule

`default_nettype wire

// File: rtl/hps_cop_cmd_sequencer.sv
//------------------------------------------------------------------------------
// Module  : hps_cop_cmd_sequencer
// Brief   : Issues one HPS PIO instruction at a time to the coprocessor and
//           reports completion status back through the WAITSIGNAL PIO.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module hps_cop_cmd_sequencer
    import cop_ctrl_pkg::*;
#(
    parameter int INSTR_W        = 32,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int CNT_W          = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [INSTR_W-1:0] pio_instr,
    input  logic               pio_start,
    output logic [1:0]         wait_signal,
    output logic [INSTR_W-1:0] cop_instr,
    output logic               cop_valid,
    input  logic               cop_ready,
    input  logic               cop_done,
    input  logic               cop_error,
    output logic [1:0]         last_status,
    output logic [CNT_W-1:0]   cmd_count
);

    state_e             state_q, state_d;
    logic               start_q;
    logic               start_rise;
    logic [1:0]         done_code;
    logic               done_entry;
    logic               tmr_clear;
    logic               tmr_enable;
    logic               tmr_expire;

    logic [1:0]         wait_signal_q, wait_signal_d;
    logic [INSTR_W-1:0] cop_instr_q, cop_instr_d;
    logic               cop_valid_q, cop_valid_d;
    logic [1:0]         last_status_q, last_status_d;
    logic [CNT_W-1:0]   cmd_count_q, cmd_count_d;

    // start_q resets high so a start level held through reset is not a new edge.
    assign start_rise = pio_start & ~start_q;
    assign tmr_clear  = (state_q == S_IDLE) && start_rise;
    assign tmr_enable = (state_q == S_ISSUE) || (state_q == S_WAIT);

    cop_timeout_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .i_clear  (tmr_clear),
        .i_enable (tmr_enable),
        .o_expire (tmr_expire)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            start_q       <= 1'b1;
            wait_signal_q <= ST_IDLE;
            cop_instr_q   <= '0;
            cop_valid_q   <= 1'b0;
            last_status_q <= ST_IDLE;
            cmd_count_q   <= '0;
        end else begin
            state_q       <= state_d;
            start_q       <= pio_start;
            wait_signal_q <= wait_signal_d;
            cop_instr_q   <= cop_instr_d;
            cop_valid_q   <= cop_valid_d;
            last_status_q <= last_status_d;
            cmd_count_q   <= cmd_count_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        done_code = ST_ERR;
        case (state_q)
            S_IDLE: begin
                if (start_rise) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // Completion in the accept cycle beats the timer; a bare done does not.
                if (cop_ready && cop_done) begin
                    state_d   = S_DONE;
                    done_code = status_for(cop_error);
                end else if (tmr_expire) begin
                    state_d   = S_DONE;
                    done_code = ST_ERR;
                end else if (cop_ready) begin
                    state_d = S_WAIT;
                end else if (!pio_start) begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (cop_done) begin
                    state_d   = S_DONE;
                    done_code = status_for(cop_error);
                end else if (tmr_expire) begin
                    state_d   = S_DONE;
                    done_code = ST_ERR;
                end
            end
            S_DONE: begin
                if (!pio_start) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        done_entry    = (state_d == S_DONE) && (state_q != S_DONE);
        cop_valid_d   = (state_d == S_ISSUE);
        cop_instr_d   = tmr_clear ? pio_instr : cop_instr_q;
        last_status_d = done_entry ? done_code : last_status_q;
        cmd_count_d   = done_entry ? (cmd_count_q + CNT_W'(1)) : cmd_count_q;
        case (state_d)
            S_IDLE:  wait_signal_d = ST_IDLE;
            S_ISSUE: wait_signal_d = ST_BUSY;
            S_WAIT:  wait_signal_d = ST_BUSY;
            default: wait_signal_d = done_entry ? done_code : wait_signal_q;
        endcase
    end

    assign wait_signal = wait_signal_q;
    assign cop_instr   = cop_instr_q;
    assign cop_valid   = cop_valid_q;
    assign last_status = last_status_q;
    assign cmd_count   = cmd_count_q;

endmodule

`default_nettype wire

// File: doc/hps_cop_cmd_sequencer.md
Name: hps_cop_cmd_sequencer

Overview:
- Sequences one HPS-issued instruction at a time into the image-filter coprocessor.
- Watches the HPS instruction and start PIO outputs, latches the instruction, and issues it to the coprocessor with a valid/ready handshake.
- Waits for completion or timeout, then reports status on the 2-bit wait_signal bus, which feeds the WAITSIGNAL input PIO read by the HPS.
- Implements the four-phase start/done handshake with software.

Parameters:
- INSTR_W, 32, width of the instruction word passed from the HPS PIO to the coprocessor.
- TIMEOUT_CYCLES, 1000000, cycles allowed from issue to cop_done; 0 disables the timeout.
- CNT_W, 16, width of the completed-command counter.

Ports:
- clk  in  1  system clock (all logic single domain).
- reset  in  1  synchronous, active-high reset.
- pio_instr  in  INSTR_W  instruction word from the HPS output PIO.
- pio_start  in  1  start level from the HPS output PIO.
- wait_signal  out  2  status to the WAITSIGNAL input PIO: 00 idle, 01 busy, 10 done ok, 11 done error/timeout.
- cop_instr  out  INSTR_W  latched instruction to the coprocessor.
- cop_valid  out  1  instruction valid to the coprocessor.
- cop_ready  in  1  coprocessor accepts instruction.
- cop_done  in  1  single-cycle completion pulse.
- cop_error  in  1  qualifies cop_done; 1 = failed.
- last_status  out  2  sticky copy of the final wait_signal code of the most recent command.
- cmd_count  out  CNT_W  completed commands, wraps modulo 2^CNT_W.

Behaviour:
- Reset values: state IDLE, wait_signal 00, cop_valid 0, cop_instr 0, last_status 00, cmd_count 0, timer 0, start_q 1.
- All outputs are registered.
- start_q resets to 1, so a pio_start still high through reset is not treated as a new command.
- Start detection: start_rise = pio_start & ~start_q; start_q <= pio_start every cycle.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE, wait_signal 00:
  - On start_rise, latch cop_instr <= pio_instr, clear the timer, and go to ISSUE.
  - wait_signal becomes 01 on the next cycle (one-cycle latency from the start edge).
- ISSUE, cop_valid 1, wait_signal 01:
  - cop_instr is held stable.
  - On cop_ready: clear cop_valid and go to WAIT.
  - If cop_done is also 1 in the same cycle, go directly to DONE using cop_error.
  - If pio_start is 0 before acceptance: withdraw, clear cop_valid, return to IDLE. No count, last_status unchanged.
- WAIT, wait_signal 01:
  - On cop_done, go to DONE with code 10 if cop_error=0, else 11.
  - pio_start falling here is ignored; the command always completes.
- Timeout:
  - The timer increments every cycle in ISSUE and WAIT and saturates.
  - When TIMEOUT_CYCLES≠0 and timer == TIMEOUT_CYCLES-1 without cop_done, go to DONE with code 11 and clear cop_valid.
  - cop_done in the same cycle as timeout expiry: cop_done wins.
- DONE:
  - On entry: wait_signal <= code, last_status <= code, cmd_count increments (wraps).
  - Holds while pio_start=1; on pio_start=0, go to IDLE and set wait_signal 00 on the next cycle.
  - If pio_start is already 0 on entry, DONE lasts one cycle. This is a software protocol violation; last_status preserves the result.
- cop_done outside WAIT, and outside the ISSUE accept cycle, is ignored.
- Reset mid-operation: immediate return to reset values. An in-flight coprocessor op is abandoned; the coprocessor must also be reset by the same signal.
- A new start_rise in ISSUE, WAIT or DONE is ignored; no queuing.

Decomposition:
- Shared package cop_ctrl_pkg:
  - state enum (IDLE/ISSUE/WAIT/DONE).
  - status codes ST_IDLE=2'b00, ST_BUSY=2'b01, ST_OK=2'b10, ST_ERR=2'b11.
- Sub-module cop_timeout_timer: clear, enable, saturating count, expire output, parameterised by TIMEOUT_CYCLES (0 = never expires).
- FSM, start edge detect and counters stay in the top level.

Test Plan:
- Nominal command: reset, pio_instr=32'hA5A5_0003, raise pio_start.
  - Next cycle: cop_valid=1, cop_instr=A5A5_0003, wait_signal=01.
  - cop_ready 2 cycles later, cop_done 10 cycles after that (cop_error=0): wait_signal=10, last_status=10, cmd_count=1.
  - Drop pio_start: wait_signal=00 one cycle later.
- Error completion: cop_done with cop_error=1 -> wait_signal=11, cmd_count increments; held until pio_start low.
- Timeout, TIMEOUT_CYCLES=20, cop_ready given but no cop_done -> wait_signal=11 exactly 20 cycles after leaving IDLE. Also check cop_done on the expiry cycle -> code 10.
- Withdrawal: start, hold cop_ready=0, drop pio_start -> cop_valid=0 next cycle, state IDLE, cmd_count unchanged, last_status unchanged.
- Reset robustness:
  - Assert reset during WAIT -> all outputs at reset values.
  - pio_start held high through reset produces no command until low then high again.
- Same-cycle accept+done in ISSUE -> DONE with code 10. Also drive 65536 commands with CNT_W=16 -> cmd_count wraps to 0.
